// File: rtl/multi_cycle_controller_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// The datapath supplies decode and status inputs; the controller returns strobes.
interface multi_cycle_controller_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       mem_ready;
  logic       x17_is_10;
  logic       pc_write;
  logic       pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       is_halted;
  logic [2:0] state;

  modport master (
    input  opcode, bcond, mem_ready, x17_is_10,
    output pc_write, pc_source, i_or_d,
    output mem_read, mem_write, ir_write,
    output mem_to_reg, reg_write, alu_src_a,
    output alu_src_b, alu_op, is_halted, state
  );

  modport slave (
    output opcode, bcond, mem_ready, x17_is_10,
    input  pc_write, pc_source, i_or_d,
    input  mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_write, alu_src_a,
    input  alu_src_b, alu_op, is_halted, state
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath: steps IF/ID/EX/MEM/WB,
// stalls on memory latency, and halts on ECALL with a7 == 10.
module multi_cycle_controller (
  input  logic clk,
  input  logic reset,
  multi_cycle_controller_if.master bus
);
  localparam logic [6:0] ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] LOAD           = 7'b0000011;
  localparam logic [6:0] STORE          = 7'b0100011;
  localparam logic [6:0] BRANCH         = 7'b1100011;
  localparam logic [6:0] JAL            = 7'b1101111;
  localparam logic [6:0] JALR           = 7'b1100111;
  localparam logic [6:0] ECALL          = 7'b1110011;

  localparam logic [1:0] ALU_CTRL_ADD   = 2'd0;
  localparam logic [1:0] ALU_CTRL_SUB   = 2'd1;
  localparam logic [1:0] ALU_CTRL_IMME  = 2'd2;
  localparam logic [1:0] ALU_CTRL_FUNCT = 2'd3;

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_BR   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  logic [2:0] state_q;
  logic [2:0] state_d;

  logic       pc_wr;
  logic       pc_src;
  logic       addr_sel;
  logic       rd_req;
  logic       wr_req;
  logic       ir_wr;
  logic       wb_sel;
  logic       rf_wr;
  logic       src_a;
  logic [1:0] src_b;
  logic [1:0] op;
  logic       halted;
  logic       known_op;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    known_op = 1'b0;
    case (bus.opcode)
      ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE,
      BRANCH, JAL, JALR, ECALL: known_op = 1'b1;
      default:                  known_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_wr    = 1'b0;
    pc_src   = 1'b0;
    addr_sel = 1'b0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    ir_wr    = 1'b0;
    wb_sel   = 1'b0;
    rf_wr    = 1'b0;
    src_a    = 1'b0;
    src_b    = 2'd0;
    op       = ALU_CTRL_ADD;
    halted   = 1'b0;
    case (state_q)
      S_IF: begin
        rd_req = 1'b1;
        if (bus.mem_ready) begin
          ir_wr   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        // ALUOut captures PC+4 here; later states reuse it.
        src_b = 2'd2;
        if (bus.opcode == ECALL && bus.x17_is_10) begin
          state_d = S_HALT;
        end else if (bus.opcode == ECALL || !known_op) begin
          pc_wr   = 1'b1;
          pc_src  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        state_d = S_IF;
        case (bus.opcode)
          ARITHMETIC: begin
            src_a   = 1'b1;
            op      = ALU_CTRL_FUNCT;
            state_d = S_WB;
          end
          ARITHMETIC_IMM: begin
            src_a   = 1'b1;
            src_b   = 2'd1;
            op      = ALU_CTRL_IMME;
            state_d = S_WB;
          end
          LOAD, STORE: begin
            src_a   = 1'b1;
            src_b   = 2'd1;
            state_d = S_MEM;
          end
          BRANCH: begin
            src_a = 1'b1;
            op    = ALU_CTRL_SUB;
            if (bus.bcond) begin
              state_d = S_BR;
            end else begin
              pc_wr  = 1'b1;
              pc_src = 1'b1;
            end
          end
          JAL, JALR: begin
            src_a = (bus.opcode == JALR);
            src_b = 2'd1;
            pc_wr = 1'b1;
            rf_wr = 1'b1;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        addr_sel = 1'b1;
        if (bus.opcode == STORE) begin
          wr_req = 1'b1;
          if (bus.mem_ready) begin
            pc_wr   = 1'b1;
            src_b   = 2'd2;
            state_d = S_IF;
          end
        end else if (bus.opcode == LOAD) begin
          rd_req = 1'b1;
          if (bus.mem_ready) state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB: begin
        rf_wr   = 1'b1;
        wb_sel  = (bus.opcode == LOAD);
        pc_wr   = 1'b1;
        src_b   = 2'd2;
        state_d = S_IF;
      end
      S_BR: begin
        src_b   = 2'd1;
        pc_wr   = 1'b1;
        state_d = S_IF;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  // Reset masks every strobe at once so an aborted instruction writes nothing.
  assign bus.pc_write   = pc_wr    & ~reset;
  assign bus.pc_source  = pc_src   & ~reset;
  assign bus.i_or_d     = addr_sel & ~reset;
  assign bus.mem_read   = rd_req   & ~reset;
  assign bus.mem_write  = wr_req   & ~reset;
  assign bus.ir_write   = ir_wr    & ~reset;
  assign bus.mem_to_reg = wb_sel   & ~reset;
  assign bus.reg_write  = rf_wr    & ~reset;
  assign bus.alu_src_a  = src_a    & ~reset;
  assign bus.alu_src_b  = reset ? 2'd0 : src_b;
  assign bus.alu_op     = reset ? 2'd0 : op;
  assign bus.is_halted  = halted   & ~reset;
  assign bus.state      = state_q;
endmodule
